// File: rtl/prco_mem_arbiter.sv
// -----------------------------------------------------------------------------
// prco_mem_arbiter
//
// Shares one single-port block RAM between the three requesters of prco_core:
// the debug/loader port (ld), the core load/store port (dt) and the core
// instruction-fetch port (if). Accesses are serialised through a four-state
// FSM (IDLE -> ACCESS -> WAIT -> DONE). Every access therefore takes four
// cycles, and the winner's ack pulses for exactly one cycle in DONE.
//
// Build option:
//   PRCO_ARB_RR_EN  When defined, data and fetch alternate round-robin on a
//                   tie. When undefined, data always beats fetch and no
//                   pointer is built. The loader always has absolute priority.
//
// Handshake (request/acknowledge):
//   A requester raises rq together with stable we/addr/wdata and holds all of
//   them until its ack pulse. It may drop rq on the edge that ends the ack
//   cycle, or keep rq high to ask for another access. That new request is
//   arbitrated in the next IDLE. A request is sampled only in IDLE. A port
//   that drops rq before it has won is never served. Once a port has won, its
//   access always completes.
//
// Ports:
//   i_clk, i_reset_n            clock; asynchronous active-low reset
//   i_ld_rq/we/addr/wdata       loader port request
//   i_dt_rq/we/addr/wdata       data port request
//   i_if_rq/addr                fetch port request (read-only)
//   q_ld_ack/q_dt_ack/q_if_ack  one-cycle completion pulses
//   q_rdata                     registered read data, held until next read
//   q_busy                      high whenever the FSM is not in IDLE
//   q_mem_en/we/addr/wdata      registered BRAM controls
//   i_mem_rdata                 BRAM read data (1-cycle latency)
//   q_state                     current FSM state, for observation
// -----------------------------------------------------------------------------
module prco_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ld_rq,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  input  logic              i_dt_rq,
  input  logic              i_dt_we,
  input  logic [ADDR_W-1:0] i_dt_addr,
  input  logic [DATA_W-1:0] i_dt_wdata,
  input  logic              i_if_rq,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              q_ld_ack,
  output logic              q_dt_ack,
  output logic              q_if_ack,
  output logic [DATA_W-1:0] q_rdata,
  output logic              q_busy,
  output logic              q_mem_en,
  output logic              q_mem_we,
  output logic [ADDR_W-1:0] q_mem_addr,
  output logic [DATA_W-1:0] q_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        q_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_LD   = 2'd1,
    ID_DT   = 2'd2,
    ID_IF   = 2'd3
  } port_id_t;

  state_t   state_q;
  state_t   state_d;
  port_id_t win_q;
  logic     lat_we_q;

  port_id_t          pick;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  // ---------------------------------------------------------------------------
  // Tie-break between data and fetch.
  // ---------------------------------------------------------------------------
`ifdef PRCO_ARB_RR_EN
  // High when fetch won the most recent data/fetch decision. It resets high,
  // so the first tie after reset goes to data. A loader win leaves it alone.
  logic rr_last_if_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_last_if_q <= 1'b1;
    end else if (state_q == S_IDLE) begin
      if (pick == ID_DT) begin
        rr_last_if_q <= 1'b0;
      end else if (pick == ID_IF) begin
        rr_last_if_q <= 1'b1;
      end
    end
  end

  logic tie_to_data;
  assign tie_to_data = rr_last_if_q;
`else
  logic tie_to_data;
  assign tie_to_data = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection. This is used only in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick = ID_NONE;
    if (i_ld_rq) begin
      pick = ID_LD;
    end else if (i_dt_rq && i_if_rq) begin
      pick = tie_to_data ? ID_DT : ID_IF;
    end else if (i_dt_rq) begin
      pick = ID_DT;
    end else if (i_if_rq) begin
      pick = ID_IF;
    end
  end

  // The fetch port can never write: its we is forced low, and it has no
  // write data.
  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    case (pick)
      ID_LD: begin
        pick_we    = i_ld_we;
        pick_addr  = i_ld_addr;
        pick_wdata = i_ld_wdata;
      end
      ID_DT: begin
        pick_we    = i_dt_we;
        pick_addr  = i_dt_addr;
        pick_wdata = i_dt_wdata;
      end
      ID_IF: begin
        pick_we    = 1'b0;
        pick_addr  = i_if_addr;
      end
      default: begin
        pick_we    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pick != ID_NONE) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and outputs.
  // The BRAM controls are loaded on the edge that leaves IDLE, so they are
  // valid for the whole ACCESS cycle. en and we fall on the next edge.
  // addr and wdata keep their values until the next access. The BRAM answers
  // one cycle after ACCESS, so read data is captured on the edge that ends
  // WAIT. The ack is registered from WAIT, so it is high only during DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      win_q       <= ID_NONE;
      lat_we_q    <= 1'b0;
      q_mem_en    <= 1'b0;
      q_mem_we    <= 1'b0;
      q_mem_addr  <= '0;
      q_mem_wdata <= '0;
      q_rdata     <= '0;
      q_ld_ack    <= 1'b0;
      q_dt_ack    <= 1'b0;
      q_if_ack    <= 1'b0;
    end else begin
      q_mem_en <= 1'b0;
      q_mem_we <= 1'b0;
      q_ld_ack <= (state_q == S_WAIT) && (win_q == ID_LD);
      q_dt_ack <= (state_q == S_WAIT) && (win_q == ID_DT);
      q_if_ack <= (state_q == S_WAIT) && (win_q == ID_IF);

      if ((state_q == S_IDLE) && (pick != ID_NONE)) begin
        win_q      <= pick;
        lat_we_q   <= pick_we;
        q_mem_en   <= 1'b1;
        q_mem_we   <= pick_we;
        q_mem_addr <= pick_addr;
        if (pick != ID_IF) begin
          q_mem_wdata <= pick_wdata;
        end
      end

      if ((state_q == S_WAIT) && !lat_we_q) begin
        q_rdata <= i_mem_rdata;
      end
    end
  end

  assign q_busy  = (state_q != S_IDLE);
  assign q_state = state_q;

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prco_mem_arbiter
//
// Directed bench for prco_mem_arbiter with a behavioural BRAM model.
// Word i of the model starts out holding 16'h1000 + i.
// -----------------------------------------------------------------------------
module tb_prco_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          ld_rq, ld_we, dt_rq, dt_we, if_rq;
  logic [AW-1:0] ld_addr, dt_addr, if_addr;
  logic [DW-1:0] ld_wdata, dt_wdata;
  logic          ld_ack, dt_ack, if_ack, busy;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    state;
  logic [2:0]    acks;

  assign acks = {ld_ack, dt_ack, if_ack};

  prco_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_ld_rq     (ld_rq),
    .i_ld_we     (ld_we),
    .i_ld_addr   (ld_addr),
    .i_ld_wdata  (ld_wdata),
    .i_dt_rq     (dt_rq),
    .i_dt_we     (dt_we),
    .i_dt_addr   (dt_addr),
    .i_dt_wdata  (dt_wdata),
    .i_if_rq     (if_rq),
    .i_if_addr   (if_addr),
    .q_ld_ack    (ld_ack),
    .q_dt_ack    (dt_ack),
    .q_if_ack    (if_ack),
    .q_rdata     (rdata),
    .q_busy      (busy),
    .q_mem_en    (mem_en),
    .q_mem_we    (mem_we),
    .q_mem_addr  (mem_addr),
    .q_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .q_state     (state)
  );

  // ---------------- BRAM model (read-before-write, 1-cycle latency) --------
  logic [DW-1:0] bram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0]    exp_q[$];
  logic [DW-1:0] exp_rd_q[$];

  localparam logic [2:0] A_LD = 3'b100;
  localparam logic [2:0] A_DT = 3'b010;
  localparam logic [2:0] A_IF = 3'b001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic          ld_rq, ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wd;
    logic          dt_rq, dt_we;
    logic [AW-1:0] dt_addr;
    logic [DW-1:0] dt_wd;
    logic          if_rq;
    logic [AW-1:0] if_addr;
    logic [2:0]    exp_ack;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string nm,
      input logic lr, input logic lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
      input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
      input logic ir, input logic [AW-1:0] ia,
      input logic [2:0] ea, input logic ew, input logic [AW-1:0] ead,
      input logic [DW-1:0] ewd, input logic [DW-1:0] erd);
    vec_t v;
    v.name = nm;
    v.ld_rq = lr; v.ld_we = lw; v.ld_addr = la; v.ld_wd = ld;
    v.dt_rq = dr; v.dt_we = dw; v.dt_addr = da; v.dt_wd = dd;
    v.if_rq = ir; v.if_addr = ia;
    v.exp_ack = ea; v.exp_we = ew; v.exp_addr = ead; v.exp_wd = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drop_all();
    ld_rq = 1'b0; dt_rq = 1'b0; if_rq = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ld_rq = v.ld_rq; ld_we = v.ld_we; ld_addr = v.ld_addr; ld_wdata = v.ld_wd;
    dt_rq = v.dt_rq; dt_we = v.dt_we; dt_addr = v.dt_addr; dt_wdata = v.dt_wd;
    if_rq = v.if_rq; if_addr = v.if_addr;
  endtask

  // Starts at the negedge on which the request was driven, with the DUT in
  // IDLE. Ends on the negedge of the following IDLE cycle.
  task automatic check_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " access.state"}, state, 2'd1);
    chk({v.name, " access.en"}, mem_en, 1'b1);
    chk({v.name, " access.we"}, mem_we, v.exp_we);
    chk({v.name, " access.addr"}, mem_addr, v.exp_addr);
    if (v.exp_we) chk({v.name, " access.wdata"}, mem_wdata, v.exp_wd);
    chk({v.name, " access.busy"}, busy, 1'b1);
    chk({v.name, " access.acks"}, acks, 3'b000);
    @(negedge clk);
    chk({v.name, " wait.state"}, state, 2'd2);
    chk({v.name, " wait.en"}, mem_en, 1'b0);
    chk({v.name, " wait.we"}, mem_we, 1'b0);
    chk({v.name, " wait.acks"}, acks, 3'b000);
    @(negedge clk);
    chk({v.name, " done.state"}, state, 2'd3);
    chk({v.name, " done.acks"}, acks, v.exp_ack);
    chk({v.name, " done.rdata"}, rdata, v.exp_rdata);
    drop_all();
    @(negedge clk);
    chk({v.name, " idle.busy"}, busy, 1'b0);
    chk({v.name, " idle.acks"}, acks, 3'b000);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main test ----------------
  initial begin
    for (int i = 0; i < 256; i++) bram[i] = 16'h1000 + 16'(i);
    ld_we = 0; ld_addr = '0; ld_wdata = '0; dt_we = 0; dt_addr = '0; dt_wdata = '0; if_addr = '0;
    drop_all();
    rst_n = 1'b0;

    //      name        ld: rq we addr data        dt: rq we addr data        if: rq addr   ack   we addr   wdata     rdata
    vecs[0]  = mk("v0_dt_wr",   0,0,8'h00,16'h0000, 1,1,8'h12,16'hBEEF, 0,8'h00, A_DT, 1,8'h12,16'hBEEF,16'h0000);
    vecs[1]  = mk("v1_if_rd",   0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 1,8'h12, A_IF, 0,8'h12,16'h0000,16'hBEEF);
    vecs[2]  = mk("v2_if_guard",0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 1,8'h05, A_IF, 0,8'h05,16'h0000,16'h1005);
    vecs[3]  = mk("v3_dt_if",   0,0,8'h00,16'h0000, 1,0,8'h12,16'h0000, 1,8'h05, A_DT, 0,8'h12,16'h0000,16'hBEEF);
    vecs[4]  = mk("v4_ld_dt",   1,1,8'h40,16'h1234, 1,0,8'h12,16'h0000, 0,8'h00, A_LD, 1,8'h40,16'h1234,16'hBEEF);
    vecs[5]  = mk("v5_dt_rd",   0,0,8'h00,16'h0000, 1,0,8'h40,16'h0000, 0,8'h00, A_DT, 0,8'h40,16'h0000,16'h1234);
    vecs[6]  = mk("v6_ld_if",   1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 1,8'h12, A_LD, 0,8'h05,16'h0000,16'h1005);
    vecs[7]  = mk("v7_all",     1,1,8'h41,16'h5678, 1,1,8'h42,16'h1111, 1,8'h12, A_LD, 1,8'h41,16'h5678,16'h1005);
    vecs[8]  = mk("v8_dt_wr",   0,0,8'h00,16'h0000, 1,1,8'h42,16'hABCD, 0,8'h00, A_DT, 1,8'h42,16'hABCD,16'h1005);
    vecs[9]  = mk("v9_ld_rd",   1,0,8'h42,16'h0000, 0,0,8'h00,16'h0000, 0,8'h00, A_LD, 0,8'h42,16'h0000,16'hABCD);
    vecs[10] = mk("v10_if_rd",  0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 1,8'h41, A_IF, 0,8'h41,16'h0000,16'h5678);
    vecs[11] = mk("v11_dt_rd",  0,0,8'h00,16'h0000, 1,0,8'h00,16'h0000, 0,8'h00, A_DT, 0,8'h00,16'h0000,16'h1000);
    vecs[12] = mk("v12_if_rd",  0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 1,8'h05, A_IF, 0,8'h05,16'h0000,16'h1005);

    // ---- reset held with a data request pending ----
    apply(vecs[0]);
    repeat (3) begin
      @(negedge clk);
      chk("rst.state", state, 2'd0);
      chk("rst.acks", acks, 3'b000);
      chk("rst.busy", busy, 1'b0);
      chk("rst.en_we", {mem_en, mem_we}, 2'b00);
      chk("rst.addr", mem_addr, 8'h00);
      chk("rst.wdata", mem_wdata, 16'h0000);
      chk("rst.rdata", rdata, 16'h0000);
    end
    rst_n = 1'b1;
    check_vec(vecs[0]);

    // ---- table ----
    for (int i = 1; i < 13; i++) begin
      apply(vecs[i]);
      check_vec(vecs[i]);
    end

    // ---- all three request in one IDLE: order ld, dt, if with 4-cycle spacing ----
    begin
      int last_cyc;
      last_cyc = -1;
      ld_rq = 1; ld_we = 0; ld_addr = 8'h00;
      dt_rq = 1; dt_we = 0; dt_addr = 8'h12;
      if_rq = 1; if_addr = 8'h05;
      exp_q.push_back(A_LD); exp_rd_q.push_back(16'h1000);
      exp_q.push_back(A_DT); exp_rd_q.push_back(16'hBEEF);
      exp_q.push_back(A_IF); exp_rd_q.push_back(16'h1005);
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(negedge clk);
        if (acks != 3'b000) begin
          if (exp_q.size() == 0) begin
            chk("sim.extra_ack", acks, 3'b000);
          end else begin
            chk("sim.order", acks, exp_q.pop_front());
            chk("sim.rdata", rdata, exp_rd_q.pop_front());
          end
          if (last_cyc >= 0) chk("sim.spacing", cyc - last_cyc, 4);
          last_cyc = cyc;
          if (ld_ack) ld_rq = 0;
          if (dt_ack) dt_rq = 0;
          if (if_ack) if_rq = 0;
          if (exp_q.size() == 0) break;
        end
      end
      chk("sim.remaining", exp_q.size(), 0);
      exp_q.delete(); exp_rd_q.delete();
      drop_all();
      @(negedge clk);
      chk("sim.idle", busy, 1'b0);
    end

    // ---- contention: dt and if hold rq for 8 accesses ----
    begin
      int n_ack;
      int last_cyc;
      n_ack = 0;
      last_cyc = -1;
      for (int k = 0; k < 8; k++) begin
`ifdef PRCO_ARB_RR_EN
        exp_q.push_back((k % 2 == 0) ? A_DT : A_IF);
`else
        exp_q.push_back(A_DT);
`endif
      end
      dt_rq = 1; dt_we = 0; dt_addr = 8'h12;
      if_rq = 1; if_addr = 8'h05;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(negedge clk);
        if (acks != 3'b000) begin
          n_ack++;
          if (exp_q.size() == 0) chk("cont.extra_ack", acks, 3'b000);
          else chk("cont.winner", acks, exp_q.pop_front());
          if (last_cyc >= 0) chk("cont.spacing", cyc - last_cyc, 4);
          last_cyc = cyc;
          if (n_ack == 8) begin
            drop_all();
            break;
          end
        end
      end
      chk("cont.count", n_ack, 8);
      chk("cont.remaining", exp_q.size(), 0);
      exp_q.delete();
      drop_all();
      @(negedge clk);
      chk("cont.idle", busy, 1'b0);
    end

    // ---- reset pulled during WAIT of a loader write ----
    ld_rq = 1; ld_we = 1; ld_addr = 8'h50; ld_wdata = 16'h9999;
    @(negedge clk);
    chk("mrst.access_we", {mem_en, mem_we}, 2'b11);
    @(negedge clk);
    chk("mrst.wait_state", state, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.we_now", mem_we, 1'b0);
    chk("mrst.en_now", mem_en, 1'b0);
    chk("mrst.state_now", state, 2'd0);
    chk("mrst.busy_now", busy, 1'b0);
    ld_rq = 0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst.no_ack", acks, 3'b000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst.after_idle", state, 2'd0);
    chk("mrst.after_ack", acks, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prco_mem_arbiter.md
# prco_mem_arbiter

Single-clock arbiter that shares one single-port block RAM between three requesters of the prco_core system: the debug/loader port, the core load/store (data) port and the core instruction-fetch port. It sits between prco_core and the board BRAM in the FPGA top level. It serialises accesses with a request/acknowledge handshake and returns registered read data.

## Interface
Parameters:
- ADDR_W, 8, word-address width of every port and of the BRAM.
- DATA_W, 16, data width.

Ports:
- i_clk  in  1  system clock (50 MHz board clock).
- i_reset_n  in  1  reset: asynchronous, active-low.
- i_ld_rq / i_ld_we / i_ld_addr / i_ld_wdata  in  1/1/ADDR_W/DATA_W  loader port request, write enable, address, write data.
- i_dt_rq / i_dt_we / i_dt_addr / i_dt_wdata  in  1/1/ADDR_W/DATA_W  data port, same meaning.
- i_if_rq / i_if_addr  in  1/ADDR_W  fetch port; read-only.
- q_ld_ack, q_dt_ack, q_if_ack  out  1 each  one-cycle completion pulse per port.
- q_rdata  out  DATA_W  registered read data, shared by all ports.
- q_busy  out  1  high in any state other than IDLE.
- q_mem_en / q_mem_we / q_mem_addr / q_mem_wdata  out  1/1/ADDR_W/DATA_W  BRAM control, all registered.
- i_mem_rdata  in  DATA_W  BRAM read data; 1-cycle read latency.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. Transitions: IDLE→ACCESS when any rq is high at a rising edge; ACCESS→WAIT, WAIT→DONE and DONE→IDLE unconditionally.
- IDLE: pick a winner, latch its id, we, addr and wdata; fetch port we is forced 0.
- Priority: loader highest always; data over fetch (fixed). Macro option below.
- ACCESS: q_mem_en=1, q_mem_we=latched we, q_mem_addr/q_mem_wdata = latched values. In every other state q_mem_en=0 and q_mem_we=0. Addr/wdata hold their last values.
- WAIT: for reads, q_rdata <= i_mem_rdata at the end of WAIT. For writes, q_rdata is unchanged.
- DONE: the winner's ack is 1 for exactly this cycle; the other acks stay 0.
- Requester rules: hold rq, we, addr and wdata stable from assertion until ack. Drop rq on the edge ending the ack cycle, or keep it high to issue a back-to-back request, which is re-arbitrated in the next IDLE.
- A request raised while the block is busy waits and is arbitrated in the next IDLE.
- A rq dropped before ack, while that port is not the winner, is simply never served. Dropping rq while that port is the winner is illegal; the access still completes and ack still pulses.
- Reset asserted mid-access aborts the access. No ack is issued, q_mem_we drops immediately, and the FSM returns to IDLE.

## Timing
- Reset values: state IDLE; q_*_ack 0; q_rdata 0; q_busy 0; q_mem_en 0; q_mem_we 0; q_mem_addr 0; q_mem_wdata 0; round-robin pointer points to fetch.
- Request high in the IDLE cycle (edge E0): ACCESS during E0–E1, WAIT E1–E2, DONE with ack E2–E3.
- Latency: ack is 3 cycles after the sampling edge.
- Throughput: one access per 4 cycles while requests are continuous.
- q_rdata is valid from the ack cycle onward and is held until the next read completes.
- q_busy is high during ACCESS, WAIT and DONE.

## Configuration
- PRCO_ARB_RR_EN defined: data and fetch alternate round-robin when both request in the same IDLE. The pointer updates only when one of those two ports wins; the loader keeps absolute priority and does not move the pointer. The first tie after reset goes to data.
- PRCO_ARB_RR_EN undefined: data always beats fetch. The pointer logic is not built.

## Test plan
- Reset: hold i_reset_n=0 while i_dt_rq=1 → all outputs 0 and no ack. Release → data access begins at the first IDLE edge.
- Write then read: data port writes addr 0x12 = 0xBEEF (ack exactly 3 cycles after sampling, q_mem_we high for exactly 1 cycle). Fetch then reads 0x12 → q_if_ack with q_rdata=0xBEEF; q_rdata is unchanged by the write.
- Simultaneous: ld, dt and if all request in one IDLE → order ld, dt, if. Each ack is a single pulse with a 4-cycle spacing.
- Contention: dt and if both hold rq continuously for 8 accesses → without the macro all 8 acks go to dt. With PRCO_ARB_RR_EN the acks alternate dt, if, dt, if….
- Mid-access reset: pull i_reset_n low during WAIT of a ld write → no q_ld_ack, q_mem_we=0 immediately, FSM back in IDLE.
- Fetch write-guard: i_if_rq=1 for addr 0x05 → q_mem_we stays 0 throughout the access and q_if_ack pulses once.
